// File: rtl/gray_conv_pipe.sv
// Pipelined bidirectional Gray<->binary converter with valid/ready flow control.
// Gray->binary resolves one MSB-first slice per stage; binary->Gray is done in stage 1.
module gray_conv_pipe #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data
);
    localparam int unsigned SLICE = (WIDTH + STAGES - 1) / STAGES;

    logic [WIDTH-1:0]  s_data   [STAGES];
    logic [STAGES-1:0] s_valid;
    logic [STAGES-1:0] s_mode;

    logic [WIDTH-1:0]  src_data [STAGES];
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] src_mode;
    logic [WIDTH-1:0]  nxt_data [STAGES];
    logic [STAGES-1:0] load;

    // The carried prefix is the lowest already-resolved binary bit, so it is
    // read back from the word itself rather than kept in a separate register.
    function automatic logic [WIDTH-1:0] resolve(
        input int unsigned      k,
        input logic             mode,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH-1:0] r;
        logic             p;
        r = d;
        p = 1'b0;
        if (mode) begin
            if (k == 0) r = d ^ (d >> 1);
        end else begin
            if (k != 0 && k * SLICE < WIDTH) p = d[WIDTH - k * SLICE];
            for (int unsigned j = 0; j < WIDTH; j++) begin
                if (j / SLICE == k) begin
                    p = p ^ d[WIDTH-1-j];
                    r[WIDTH-1-j] = p;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        src_valid   = '0;
        src_mode    = '0;
        src_data[0] = in_data;
        src_valid[0] = in_valid;
        src_mode[0]  = in_mode;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_data[k]  = s_data[k-1];
            src_valid[k] = s_valid[k-1];
            src_mode[k]  = s_mode[k-1];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            nxt_data[k] = resolve(k, src_mode[k], src_data[k]);
        end
    end

    always_comb begin
        logic down_ready;
        down_ready = out_ready;
        load       = '0;
        for (int unsigned n = 0; n < STAGES; n++) begin
            load[STAGES-1-n] = ~s_valid[STAGES-1-n] | down_ready;
            down_ready       = load[STAGES-1-n];
        end
        in_ready = load[0] & ~srst;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            s_valid <= '0;
            s_mode  <= '0;
            for (int unsigned k = 0; k < STAGES; k++) s_data[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    s_valid[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        s_data[k] <= nxt_data[k];
                        s_mode[k] <= src_mode[k];
                    end
                end
            end
        end
    end

    assign out_valid = s_valid[STAGES-1];
    assign out_mode  = s_mode[STAGES-1];
    assign out_data  = s_data[STAGES-1];

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Directed bench for gray_conv_pipe: WIDTH=4 STAGES=2 vectors, backpressure, reset,
// plus WIDTH=16 instances with STAGES 1, 3 and 16 checked against a reference model.
module tb_gray_conv_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       srst, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
    logic [3:0] in_data, out_data;

    gray_conv_pipe #(.WIDTH(4), .STAGES(2)) dut (
        .clk(clk), .srst(srst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data)
    );

    logic        w_in_valid, w_in_mode, w_out_ready;
    logic [15:0] w_in_data;
    logic [2:0]  w_in_ready, w_out_valid, w_out_mode;
    logic [15:0] w_out_data [3];

    gray_conv_pipe #(.WIDTH(16), .STAGES(1)) dut_w1 (
        .clk(clk), .srst(srst), .in_valid(w_in_valid), .in_ready(w_in_ready[0]),
        .in_mode(w_in_mode), .in_data(w_in_data), .out_valid(w_out_valid[0]),
        .out_ready(w_out_ready), .out_mode(w_out_mode[0]), .out_data(w_out_data[0])
    );
    gray_conv_pipe #(.WIDTH(16), .STAGES(3)) dut_w3 (
        .clk(clk), .srst(srst), .in_valid(w_in_valid), .in_ready(w_in_ready[1]),
        .in_mode(w_in_mode), .in_data(w_in_data), .out_valid(w_out_valid[1]),
        .out_ready(w_out_ready), .out_mode(w_out_mode[1]), .out_data(w_out_data[1])
    );
    gray_conv_pipe #(.WIDTH(16), .STAGES(16)) dut_w16 (
        .clk(clk), .srst(srst), .in_valid(w_in_valid), .in_ready(w_in_ready[2]),
        .in_mode(w_in_mode), .in_data(w_in_data), .out_valid(w_out_valid[2]),
        .out_ready(w_out_ready), .out_mode(w_out_mode[2]), .out_data(w_out_data[2])
    );

    int tests = 0;
    int fails = 0;

    logic [3:0] vdata [32];
    logic [3:0] vexp  [32];
    logic [3:0] got   [32];
    logic       vmode [32];

    logic [16:0] q0 [$];
    logic [16:0] q1 [$];
    logic [16:0] q2 [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] g2b(input logic [15:0] x, input int w);
        logic [15:0] r;
        r = '0;
        r[w-1] = x[w-1];
        for (int i = w - 2; i >= 0; i--) r[i] = r[i+1] ^ x[i];
        return r;
    endfunction

    function automatic logic [15:0] b2g(input logic [15:0] x);
        return x ^ (x >> 1);
    endfunction

    // Single word on the 4-bit pipe; checks latency, result and mode.
    task automatic send4(input logic mode, input logic [3:0] data, input logic [3:0] exp, input string tag);
        int cyc;
        in_valid  = 1'b1;
        in_mode   = mode;
        in_data   = data;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 2);
        check({tag, "_data"}, out_data, exp);
        check({tag, "_mode"}, out_mode, mode);
        tick();
        check({tag, "_drained"}, out_valid, 0);
    endtask

    // Streams n vector words; out_ready is held low for the first 'hold' cycles.
    task automatic stream4(input int n, input int hold, input string tag);
        int wr, rd, stalls;
        bit hs_in, hs_out;
        wr = 0;
        rd = 0;
        stalls = 0;
        for (int c = 0; c < n + hold + 20 && rd < n; c++) begin
            in_valid = (wr < n);
            if (wr < n) begin
                in_mode = vmode[wr];
                in_data = vdata[wr];
            end else begin
                in_mode = 1'b0;
                in_data = '0;
            end
            out_ready = (c >= hold);
            #1;
            if (hold > 0 && c == hold - 1) begin
                check({tag, "_accepts_when_full"}, wr, 2);
                check({tag, "_in_ready_when_full"}, in_ready, 0);
            end
            if (out_valid) begin
                check($sformatf("%s_data%0d", tag, rd), out_data, vexp[rd]);
                check($sformatf("%s_mode%0d", tag, rd), out_mode, vmode[rd]);
            end
            if (hold == 0 && in_valid && !in_ready) stalls++;
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                got[rd] = out_data;
                rd++;
            end
            tick();
            if (hs_in) wr++;
        end
        check({tag, "_count"}, rd, n);
        check({tag, "_stalls"}, stalls, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check({tag, "_no_dup"}, out_valid, 0);
    endtask

    task automatic wpop(input int d, output logic [16:0] v, output bit ok);
        ok = 1'b0;
        v  = 'x;
        case (d)
            0: if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic wpush(input int d, input logic [16:0] v);
        case (d)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic wcycle();
        logic [16:0] expv, v;
        bit ok;
        #1;
        expv = {w_in_mode, w_in_mode ? b2g(w_in_data) : g2b(w_in_data, 16)};
        for (int d = 0; d < 3; d++) begin
            if (w_out_valid[d] && w_out_ready) begin
                wpop(d, v, ok);
                check($sformatf("w%0d_expected_word", d), ok, 1);
                check($sformatf("w%0d_result", d), {w_out_mode[d], w_out_data[d]}, v);
            end
            if (w_in_valid && w_in_ready[d]) wpush(d, expv);
        end
        tick();
    endtask

    initial begin
        int stg [3];
        int lat [3];
        logic [3:0] bp [6];

        stg = '{1, 3, 16};
        srst = 1'b1;
        in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_mode = 1'b0; w_in_data = '0; w_out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_mode", out_mode, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_w_out_valid", w_out_valid, 0);
        srst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Directed vectors
        send4(1'b0, 4'b1011, 4'b1101, "g2b_1011");
        send4(1'b1, 4'b1101, 4'b1011, "b2g_1101");
        send4(1'b1, 4'b1111, 4'b1000, "b2g_1111");
        send4(1'b0, 4'b1000, 4'b1111, "g2b_1000");
        send4(1'b0, 4'b0000, 4'b0000, "g2b_0000");
        send4(1'b0, 4'b1111, 4'b1010, "g2b_1111");

        // Back-to-back sweep with alternating modes
        for (int i = 0; i < 16; i++) begin
            vmode[i] = i[0];
            vdata[i] = 4'(i);
            vexp[i]  = i[0] ? 4'(b2g(16'(i))) : 4'(g2b(16'(i), 4));
        end
        stream4(16, 0, "sweep");

        // Round trip bin->gray->bin
        for (int i = 0; i < 16; i++) begin
            vmode[i] = 1'b1;
            vdata[i] = 4'(i);
            vexp[i]  = 4'(b2g(16'(i)));
        end
        stream4(16, 0, "to_gray");
        for (int i = 0; i < 16; i++) begin
            vmode[i] = 1'b0;
            vdata[i] = got[i];
            vexp[i]  = 4'(i);
        end
        stream4(16, 0, "round_trip");

        // Backpressure: out_ready low for 6 cycles while streaming
        bp = '{4'h3, 4'h5, 4'h9, 4'hc, 4'h6, 4'hf};
        for (int i = 0; i < 6; i++) begin
            vmode[i] = i[0];
            vdata[i] = bp[i];
            vexp[i]  = i[0] ? 4'(b2g(16'(bp[i]))) : 4'(g2b(16'(bp[i]), 4));
        end
        stream4(6, 6, "backpressure");

        // Reset with two words in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        in_data   = 4'b1011;
        tick();
        in_data = 4'b0101;
        tick();
        in_valid = 1'b0;
        check("midrst_full", out_valid, 1);
        srst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 0);
        tick();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_mode", out_mode, 0);
        srst = 1'b0;
        send4(1'b0, 4'b0110, 4'b0100, "after_rst");

        // Wide instances: latency with MSB-only Gray word
        w_out_ready = 1'b1;
        w_in_valid  = 1'b1;
        w_in_mode   = 1'b0;
        w_in_data   = 16'h8000;
        #1;
        check("w_in_ready_idle", w_in_ready, 3'b111);
        tick();
        w_in_valid = 1'b0;
        lat = '{0, 0, 0};
        for (int c = 1; c <= 20; c++) begin
            for (int d = 0; d < 3; d++) begin
                if (w_out_valid[d] && lat[d] == 0) begin
                    lat[d] = c;
                    check($sformatf("w%0d_msb_only", d), w_out_data[d], 16'hffff);
                end
            end
            tick();
        end
        for (int d = 0; d < 3; d++) check($sformatf("w%0d_latency", d), lat[d], stg[d]);

        // Wide instances: random mixed-mode traffic with random valid/ready
        for (int c = 0; c < 600; c++) begin
            w_in_valid  = ($urandom_range(0, 3) != 0);
            w_in_mode   = 1'($urandom_range(0, 1));
            w_in_data   = 16'($urandom);
            w_out_ready = ($urandom_range(0, 3) != 0);
            wcycle();
        end
        w_in_valid  = 1'b0;
        w_out_ready = 1'b1;
        for (int c = 0; c < 40; c++) wcycle();
        check("w0_drained", q0.size(), 0);
        check("w1_drained", q1.size(), 0);
        check("w2_drained", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
